// File: rtl/cpu_program_counter.sv
// cpu_program_counter
// 16-bit 6502 program counter (PCH:PCL) for the Famicom CPU core.
// Each byte selects either its address bus (ADL/ADH) or its own current
// value; the combined 16-bit value is then optionally incremented by one.
// Optional feature macro: PC_PH2_GATE_EN. When defined, the register only
// updates on edges where clk_ph2_enable is high; reset still acts on every edge.
module cpu_program_counter #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       clk_ph2_enable,
  input  logic [7:0] ADL_in,
  input  logic [7:0] ADH_in,
  input  logic       INC_en,
  input  logic       PCL_in_enable,
  input  logic       PCH_in_enable,
  input  logic       ADL_in_en,
  input  logic       ADH_in_en,
  output logic [7:0] PCL_out,
  output logic [7:0] PCH_out
);

  logic [15:0]      pc_reg;
  logic [15:0]      pc_next;
  logic [1:0][7:0]  ad_bus;
  logic [1:0]       ad_en;
  logic [1:0][7:0]  src_byte;
  logic             update_en;

  // Explicit-hold selects behave the same as the default (all selects low),
  // so they carry no logic; the bus enables always take priority over them.
  logic unused_hold_sel;
  assign unused_hold_sel = &{1'b0, PCL_in_enable, PCH_in_enable};

  assign ad_bus = {ADH_in, ADL_in};
  assign ad_en  = {ADH_in_en, ADL_in_en};

  // Per-byte source mux: index 0 is the low byte (PCL), 1 is the high byte (PCH).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_byte[gi] = ad_en[gi] ? ad_bus[gi] : pc_reg[gi*8 +: 8];
    end
  endgenerate

`ifdef PC_PH2_GATE_EN
  assign update_en = clk_ph2_enable;
`else
  logic unused_ph2;
  assign unused_ph2 = clk_ph2_enable;
  assign update_en  = 1'b1;
`endif

  // Load first, then increment; the 16-bit add wraps FFFF -> 0000 with no carry out.
  always_comb begin
    pc_next = src_byte + {15'd0, INC_en};
  end

  // PC register: reset wins over everything, including the phase-2 gate.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (update_en) begin
      pc_reg <= pc_next;
    end
  end

  assign PCL_out = pc_reg[7:0];
  assign PCH_out = pc_reg[15:8];

endmodule

// File: tb/tb_cpu_program_counter.sv
// tb_cpu_program_counter
// Scoreboard bench: each step drives inputs on the falling edge, pushes the
// reference-model result to a queue, and pops/compares after the rising edge.
// Follows PC_PH2_GATE_EN the same way the design does.
module tb_cpu_program_counter;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       clk_ph2_enable;
  logic [7:0] ADL_in;
  logic [7:0] ADH_in;
  logic       INC_en;
  logic       PCL_in_enable;
  logic       PCH_in_enable;
  logic       ADL_in_en;
  logic       ADH_in_en;
  logic [7:0] PCL_out;
  logic [7:0] PCH_out;

  always #5 sys_clock = ~sys_clock;

  cpu_program_counter #(.RESET_PC(16'h0000)) dut (
    .sys_clock      (sys_clock),
    .reset          (reset),
    .clk_ph2_enable (clk_ph2_enable),
    .ADL_in         (ADL_in),
    .ADH_in         (ADH_in),
    .INC_en         (INC_en),
    .PCL_in_enable  (PCL_in_enable),
    .PCH_in_enable  (PCH_in_enable),
    .ADL_in_en      (ADL_in_en),
    .ADH_in_en      (ADH_in_en),
    .PCL_out        (PCL_out),
    .PCH_out        (PCH_out)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_pc;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, exp);
    end
  endtask

  // One transaction: drive, predict, wait one edge, compare.
  task automatic step(input string tag, input logic rst, input logic [7:0] adl,
                      input logic [7:0] adh, input logic inc, input logic pcl_e,
                      input logic pch_e, input logic adl_e, input logic adh_e,
                      input logic ph2);
    logic [7:0]  sl;
    logic [7:0]  sh;
    logic [15:0] nxt;
    logic [15:0] got;
    @(negedge sys_clock);
    reset = rst; ADL_in = adl; ADH_in = adh; INC_en = inc;
    PCL_in_enable = pcl_e; PCH_in_enable = pch_e;
    ADL_in_en = adl_e; ADH_in_en = adh_e; clk_ph2_enable = ph2;
    sl  = adl_e ? adl : model_pc[7:0];
    sh  = adh_e ? adh : model_pc[15:8];
    nxt = {sh, sl} + {15'd0, inc};
`ifdef PC_PH2_GATE_EN
    if (!ph2) nxt = model_pc;
`endif
    if (rst) nxt = 16'h0000;
    model_pc = nxt;
    exp_q.push_back(nxt);
    tag_q.push_back(tag);
    @(posedge sys_clock);
    #1;
    got = {PCH_out, PCL_out};
    $display("txn %-10s pc=%04h exp=%04h", tag, got, exp_q[0]);
    check_val(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  // Outputs must not follow input changes between edges.
  task automatic check_no_comb_path();
    ADL_in = ~ADL_in; ADH_in = ~ADH_in; ADL_in_en = 1'b1; ADH_in_en = 1'b1;
    INC_en = ~INC_en; reset = 1'b1;
    #2;
    check_val("no_comb", {PCH_out, PCL_out}, model_pc);
    reset = 1'b0;
  endtask

  initial begin
    model_pc = 16'h0000;
    reset = 1'b1; clk_ph2_enable = 1'b1; ADL_in = '0; ADH_in = '0; INC_en = 1'b0;
    PCL_in_enable = 1'b0; PCH_in_enable = 1'b0; ADL_in_en = 1'b0; ADH_in_en = 1'b0;

    // reset, then count up
    step("reset", 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("inc", 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1);
    // full bus load
    for (int i = 0; i < 5; i++) step("load", 0, 8'h55, 8'hAA, 0, 0, 0, 1, 1, 1);
    check_no_comb_path();
    // explicit hold and idle hold
    for (int i = 0; i < 5; i++) step("hold", 0, 8'h11, 8'h22, 0, 1, 1, 0, 0, 1);
    step("idle", 0, 8'h33, 8'h44, 0, 0, 0, 0, 0, 1);
    // bus enable beats explicit hold
    step("priority", 0, 8'h5A, 8'hA5, 0, 1, 1, 1, 1, 1);
    // load + increment in one cycle
    step("load_inc", 0, 8'h55, 8'hAA, 1, 0, 0, 1, 1, 1);
    // low-byte carry into high byte, and 16-bit wrap
    step("ld_12ff", 0, 8'hFF, 8'h12, 0, 0, 0, 1, 1, 1);
    step("carry", 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1);
    step("ld_ffff", 0, 8'hFF, 8'hFF, 0, 0, 0, 1, 1, 1);
    step("wrap", 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1);
    // mixed loads
    step("ld_3400", 0, 8'h00, 8'h34, 0, 0, 0, 1, 1, 1);
    step("mix_lo", 0, 8'h10, 8'h99, 1, 0, 0, 1, 0, 1);
    step("mix_hi", 0, 8'h77, 8'h5C, 0, 0, 0, 0, 1, 1);
    // reset overrides a concurrent load+increment
    step("rst_load", 1, 8'h55, 8'hAA, 1, 0, 0, 1, 1, 1);
    // phase-2 gating (ignored in the default build, model follows the build)
    step("ld_0100", 0, 8'h00, 8'h01, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step("ph2_low", 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("ph2_alt", 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1'(i % 2));
    step("ph2_ld", 0, 8'hEE, 8'hDD, 0, 0, 0, 1, 1, 0);
    step("rst_noph2", 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    // random mix
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover=%0d", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
